// File: rtl/vga_test_pattern_gen_pkg.sv
// Shared definitions for the VGA test-pattern generator: mode codes, palette,
// output payload and 720p default timing.
package vga_test_pattern_gen_pkg;

  localparam int unsigned PIXEL_W = 24;
  localparam int unsigned MODE_W  = 3;

  localparam int unsigned H_ACTIVE_DEF = 1280;
  localparam int unsigned H_FP_DEF     = 110;
  localparam int unsigned H_SYNC_DEF   = 40;
  localparam int unsigned H_BP_DEF     = 220;
  localparam int unsigned V_ACTIVE_DEF = 720;
  localparam int unsigned V_FP_DEF     = 5;
  localparam int unsigned V_SYNC_DEF   = 5;
  localparam int unsigned V_BP_DEF     = 20;

  typedef enum logic [MODE_W-1:0] {
    MODE_VBARS   = 3'd0,
    MODE_HBARS   = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_SCROLL  = 3'd3,
    MODE_CYCLE   = 3'd4
  } mode_e;

  typedef struct packed {
    logic [PIXEL_W-1:0] pixel;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               fs;
  } vid_out_t;

  // Eight-entry colour palette shared by every bar-style mode.
  function automatic logic [PIXEL_W-1:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 24'h0000ff;
      3'd1:    palette = 24'h00ff00;
      3'd2:    palette = 24'hff0000;
      3'd3:    palette = 24'hffffff;
      3'd4:    palette = 24'hffff00;
      3'd5:    palette = 24'h00ffff;
      3'd6:    palette = 24'hff00ff;
      default: palette = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/vga_test_pattern_gen_if.sv
// Video output bundle towards the encoder plus the pattern-select input.
interface vga_test_pattern_gen_if;
  import vga_test_pattern_gen_pkg::*;

  logic [MODE_W-1:0]  mode_in;
  logic [PIXEL_W-1:0] pixel;
  logic               hsync_out;
  logic               vsync_out;
  logic               pVDE;
  logic               frame_start;

  modport master (
    input  mode_in,
    output pixel, hsync_out, vsync_out, pVDE, frame_start
  );

  modport slave (
    output mode_in,
    input  pixel, hsync_out, vsync_out, pVDE, frame_start
  );

endinterface

// File: rtl/vga_test_pattern_gen_timing_core.sv
// H/V raster counters with combinational sync, active-area, frame-start and
// frame-end decode of the current counter position.
module vga_test_pattern_gen_timing_core #(
  parameter  int unsigned H_ACTIVE = 1280,
  parameter  int unsigned H_FP     = 110,
  parameter  int unsigned H_SYNC   = 40,
  parameter  int unsigned H_BP     = 220,
  parameter  int unsigned V_ACTIVE = 720,
  parameter  int unsigned V_FP     = 5,
  parameter  int unsigned V_SYNC   = 5,
  parameter  int unsigned V_BP     = 20,
  parameter  bit          HS_POL   = 1'b1,
  parameter  bit          VS_POL   = 1'b1,
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HCNT_W   = $clog2(H_TOTAL + 1),
  localparam int unsigned VCNT_W   = $clog2(V_TOTAL + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [HCNT_W-1:0] o_hcnt,
  output logic [VCNT_W-1:0] o_vcnt,
  output logic              o_active_c,
  output logic              o_hsync_c,
  output logic              o_vsync_c,
  output logic              o_frame_start_c,
  output logic              o_frame_end_c
);

  logic [HCNT_W-1:0] r_hcnt;
  logic [VCNT_W-1:0] r_vcnt;
  logic              w_line_end;
  logic              w_in_hsync;
  logic              w_in_vsync;

  assign w_line_end = (r_hcnt == HCNT_W'(H_TOTAL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else if (w_line_end) begin
      r_hcnt <= '0;
      r_vcnt <= o_frame_end_c ? '0 : r_vcnt + VCNT_W'(1);
    end else begin
      r_hcnt <= r_hcnt + HCNT_W'(1);
    end
  end

  // Sync windows sit after the front porch: active, FP, SYNC, BP.
  assign w_in_hsync = (r_hcnt >= HCNT_W'(H_ACTIVE + H_FP)) &&
                      (r_hcnt <  HCNT_W'(H_ACTIVE + H_FP + H_SYNC));
  assign w_in_vsync = (r_vcnt >= VCNT_W'(V_ACTIVE + V_FP)) &&
                      (r_vcnt <  VCNT_W'(V_ACTIVE + V_FP + V_SYNC));

  assign o_hcnt          = r_hcnt;
  assign o_vcnt          = r_vcnt;
  assign o_hsync_c       = w_in_hsync ? HS_POL : ~HS_POL;
  assign o_vsync_c       = w_in_vsync ? VS_POL : ~VS_POL;
  assign o_active_c      = (r_hcnt < HCNT_W'(H_ACTIVE)) && (r_vcnt < VCNT_W'(V_ACTIVE));
  assign o_frame_start_c = (r_hcnt == '0) && (r_vcnt == '0);
  assign o_frame_end_c   = w_line_end && (r_vcnt == VCNT_W'(V_TOTAL - 1));

endmodule

// File: rtl/vga_test_pattern_gen.sv
// Parametrised VGA/DVI test-pattern generator: raster timing, frame-latched
// pattern mode, scroll/colour-cycle state and a two-stage output pipeline.
module vga_test_pattern_gen
  import vga_test_pattern_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = H_ACTIVE_DEF,
  parameter int unsigned H_FP         = H_FP_DEF,
  parameter int unsigned H_SYNC       = H_SYNC_DEF,
  parameter int unsigned H_BP         = H_BP_DEF,
  parameter int unsigned V_ACTIVE     = V_ACTIVE_DEF,
  parameter int unsigned V_FP         = V_FP_DEF,
  parameter int unsigned V_SYNC       = V_SYNC_DEF,
  parameter int unsigned V_BP         = V_BP_DEF,
  parameter bit          HS_POL       = 1'b1,
  parameter bit          VS_POL       = 1'b1,
  parameter int unsigned NUM_BARS     = 3,
  parameter int unsigned CHECKER_LOG2 = 6,
  parameter int unsigned SCROLL_STEP  = 4,
  parameter int unsigned CYCLE_LOG2   = 6
) (
  input logic                    clk,
  input logic                    reset,
  vga_test_pattern_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCNT_W  = $clog2(H_TOTAL + 1);
  localparam int unsigned VCNT_W  = $clog2(V_TOTAL + 1);
  localparam int unsigned OFF_W   = $clog2(H_ACTIVE + 1);
  localparam int unsigned XW      = $clog2(2 * H_ACTIVE);
  localparam int unsigned FCTR_W  = CYCLE_LOG2 + 3;

  localparam vid_out_t IDLE = '{pixel: PIXEL_W'(0), hsync: ~HS_POL, vsync: ~VS_POL,
                                de: 1'b0, fs: 1'b0};

  logic [HCNT_W-1:0]  w_hcnt;
  logic [VCNT_W-1:0]  w_vcnt;
  logic               w_active;
  logic               w_hsync;
  logic               w_vsync;
  logic               w_frame_start;
  logic               w_frame_end;

  mode_e              r_mode;
  logic [OFF_W-1:0]   r_offset;
  logic [FCTR_W-1:0]  r_frame_ctr;
  vid_out_t           r_s1;
  vid_out_t           r_s2;

  mode_e              w_mode;
  logic [31:0]        w_hx;
  logic [31:0]        w_vy;
  logic [XW-1:0]      w_off_sum;
  logic [OFF_W-1:0]   w_off_next;
  logic [XW-1:0]      w_xsum;
  logic [XW-1:0]      w_x;
  logic               w_chk;
  logic [PIXEL_W-1:0] w_rgb;

  vga_test_pattern_gen_timing_core #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HS_POL   (HS_POL),   .VS_POL (VS_POL)
  ) u_timing (
    .clk             (clk),
    .reset           (reset),
    .o_hcnt          (w_hcnt),
    .o_vcnt          (w_vcnt),
    .o_active_c      (w_active),
    .o_hsync_c       (w_hsync),
    .o_vsync_c       (w_vsync),
    .o_frame_start_c (w_frame_start),
    .o_frame_end_c   (w_frame_end)
  );

  // Bar index: number of constant boundaries (k*span)/NUM_BARS that c has reached.
  function automatic logic [2:0] bar_idx(input logic [31:0] c, input int unsigned span);
    bar_idx = 3'd0;
    for (int unsigned k = 1; k < NUM_BARS; k++) begin
      if (c >= 32'((k * span) / NUM_BARS)) bar_idx = bar_idx + 3'd1;
    end
  endfunction

  // The first pixel of a frame already uses the newly sampled mode.
  assign w_mode = w_frame_start ? mode_e'(bus.mode_in) : r_mode;
  assign w_hx   = 32'(w_hcnt);
  assign w_vy   = 32'(w_vcnt);
  assign w_chk  = w_hx[CHECKER_LOG2] ^ w_vy[CHECKER_LOG2];

  assign w_off_sum  = XW'(r_offset) + XW'(SCROLL_STEP);
  assign w_off_next = (w_off_sum >= XW'(H_ACTIVE)) ? OFF_W'(w_off_sum - XW'(H_ACTIVE))
                                                    : OFF_W'(w_off_sum);
  assign w_xsum     = XW'(w_hcnt) + XW'(r_offset);
  assign w_x        = (w_xsum >= XW'(H_ACTIVE)) ? w_xsum - XW'(H_ACTIVE) : w_xsum;

  always_comb begin
    w_rgb = '0;
    case (w_mode)
      MODE_VBARS:   w_rgb = palette(bar_idx(w_hx, H_ACTIVE));
      MODE_HBARS:   w_rgb = palette(bar_idx(w_vy, V_ACTIVE));
      MODE_CHECKER: w_rgb = w_chk ? 24'h000000 : 24'hffffff;
      MODE_SCROLL:  w_rgb = palette(bar_idx(32'(w_x), H_ACTIVE));
      MODE_CYCLE:   w_rgb = palette(r_frame_ctr[CYCLE_LOG2 +: 3]);
      default:      w_rgb = '0;
    endcase
    if (!w_active) w_rgb = '0;
  end

  // Stage 1 captures the decode, stage 2 re-registers it towards the encoder.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= MODE_VBARS;
      r_offset    <= '0;
      r_frame_ctr <= '0;
      r_s1        <= IDLE;
      r_s2        <= IDLE;
    end else begin
      if (w_frame_start) r_mode <= w_mode;
      if (w_frame_end) begin
        r_offset    <= w_off_next;
        r_frame_ctr <= r_frame_ctr + FCTR_W'(1);
      end
      r_s1 <= '{pixel: w_rgb, hsync: w_hsync, vsync: w_vsync, de: w_active, fs: w_frame_start};
      r_s2 <= r_s1;
    end
  end

  assign bus.pixel       = r_s2.pixel;
  assign bus.hsync_out   = r_s2.hsync;
  assign bus.vsync_out   = r_s2.vsync;
  assign bus.pVDE        = r_s2.de;
  assign bus.frame_start = r_s2.fs;

endmodule

// File: tb/tb_vga_test_pattern_gen.sv
// Scoreboard bench: a raster-position reference model predicts every output
// cycle; a monitor pops and compares after each clock edge.
module tb_vga_test_pattern_gen;

  localparam int unsigned HA = 40, HFP = 4, HSY = 4, HBP = 6;
  localparam int unsigned VA = 20, VFP = 2, VSY = 2, VBP = 3;
  localparam int unsigned HT = HA + HFP + HSY + HBP;
  localparam int unsigned VT = VA + VFP + VSY + VBP;
  localparam int unsigned FRAME = HT * VT;
  localparam bit          HPOL = 1'b1, VPOL = 1'b0;
  localparam int unsigned NB = 3, CL = 2, STEP = 7, CYC = 1;

  typedef struct packed {
    logic [23:0] pixel;
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  vga_test_pattern_gen_if bus();

  vga_test_pattern_gen #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .HS_POL (HPOL), .VS_POL (VPOL), .NUM_BARS (NB), .CHECKER_LOG2 (CL),
    .SCROLL_STEP (STEP), .CYCLE_LOG2 (CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cnt     = 0;
  bit          prev_rst = 1'b1;
  logic [2:0]  fmode   = 3'd0;

  function automatic logic [23:0] pal(input int unsigned i);
    case (i % 8)
      0:       return 24'h0000ff;
      1:       return 24'h00ff00;
      2:       return 24'hff0000;
      3:       return 24'hffffff;
      4:       return 24'hffff00;
      5:       return 24'h00ffff;
      6:       return 24'hff00ff;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic int unsigned bar(input int unsigned c, input int unsigned s);
    int unsigned b;
    b = 0;
    for (int unsigned k = 1; k < NB; k++) if (c >= (k * s) / NB) b++;
    return b;
  endfunction

  function automatic exp_t idle();
    exp_t e;
    e.pixel = 24'h0; e.hs = ~HPOL; e.vs = ~VPOL; e.de = 1'b0; e.fs = 1'b0;
    return e;
  endfunction

  // Expected output for raster position p (cycles since reset) in mode md.
  function automatic exp_t model(input int unsigned p, input logic [2:0] md);
    exp_t        e;
    int unsigned f, q, h, v;
    f = p / FRAME;
    q = p % FRAME;
    h = q % HT;
    v = q / HT;
    e.hs    = (h >= HA + HFP && h < HA + HFP + HSY) ? HPOL : ~HPOL;
    e.vs    = (v >= VA + VFP && v < VA + VFP + VSY) ? VPOL : ~VPOL;
    e.de    = (h < HA) && (v < VA);
    e.fs    = (q == 0);
    e.pixel = 24'h0;
    if (e.de) begin
      case (md)
        3'd0:    e.pixel = pal(bar(h, HA));
        3'd1:    e.pixel = pal(bar(v, VA));
        3'd2:    e.pixel = (((h >> CL) ^ (v >> CL)) & 1) != 0 ? 24'h000000 : 24'hffffff;
        3'd3:    e.pixel = pal(bar((h + f * STEP) % HA, HA));
        3'd4:    e.pixel = pal((f >> CYC) % 8);
        default: e.pixel = 24'h0;
      endcase
    end
    return e;
  endfunction

  // Drive one clock worth of inputs and predict the output after the coming edge.
  task automatic drive(input logic rst, input logic [2:0] md);
    @(negedge clk);
    reset       = rst;
    bus.mode_in = md;
    if (rst || prev_rst) exp_q.push_back(idle());
    else                 exp_q.push_back(model(cnt - 1, fmode));
    if (rst) cnt = 0;
    else begin
      if (cnt % FRAME == 0) fmode = md;
      cnt++;
    end
    prev_rst = rst;
  endtask

  task automatic run(input logic [2:0] md, input int unsigned ncyc, input bit change);
    int unsigned at;
    logic [2:0]  alt;
    at  = $urandom_range(FRAME - 1, 1);
    alt = 3'($urandom_range(7));
    for (int unsigned i = 0; i < ncyc; i++) drive(1'b0, (change && i >= at) ? alt : md);
  endtask

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pixel", bus.pixel, e.pixel);
        chk("hsync", 24'(bus.hsync_out), 24'(e.hs));
        chk("vsync", 24'(bus.vsync_out), 24'(e.vs));
        chk("pVDE", 24'(bus.pVDE), 24'(e.de));
        chk("frame_start", 24'(bus.frame_start), 24'(e.fs));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    bus.mode_in = 3'd0;
    repeat (3) drive(1'b1, 3'd0);
    for (int m = 0; m < 8; m++) run(3'(m), FRAME, 1'b1);
    repeat (6) run(3'd3, FRAME, 1'b0);
    repeat (6) run(3'd4, FRAME, 1'b0);
    repeat (4) run(3'($urandom_range(4)), FRAME, 1'b1);
    // Mid-frame reset: restart the raster from a random point of an active line.
    run(3'd2, $urandom_range(FRAME / 2, HT * 3), 1'b0);
    repeat ($urandom_range(3, 1)) drive(1'b1, 3'($urandom_range(7)));
    repeat (3) run(3'($urandom_range(7)), FRAME, 1'b1);
    run(3'd0, 5, 1'b0);
    @(posedge clk);
    #3;
    chk("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
